// File: rtl/regfile_sequencer.sv
// regfile_sequencer
// Expands MOV / SWAP / CLR / INC / DEC commands into one to three
// register-file cycles. It drives the read-port selects, function
// code and per-register write enables of the R1-R4 / S1-S4 register file.
// The register file's I input is wired to its own OutA, so every load
// copies the register that OutASel points at.
//
// Optional feature macro: REGFILE_SEQ_SWAP_EN
//   defined   -> SWAP is supported through STEP2/STEP3, with S4 as the temporary
//   undefined -> SWAP is rejected with an Err pulse and the FSM is IDLE/STEP1 only
//
// Every output is a flop. Next values are computed from the current state,
// the latched command fields, or the command being accepted, so no
// combinational path runs from the Cmd* inputs to any output.

module regfile_sequencer (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       CmdValid,
  output logic       CmdReady,
  input  logic [2:0] CmdOp,
  input  logic [2:0] CmdSrc,
  input  logic [2:0] CmdDst,
  output logic [2:0] OutASel,
  output logic [2:0] OutBSel,
  output logic [2:0] FunSel,
  output logic [3:0] RegSel,
  output logic [3:0] ScrSel,
  output logic       Done,
  output logic       Err
);

  // Command opcodes
  localparam logic [2:0] OP_MOV  = 3'd0;
  localparam logic [2:0] OP_SWAP = 3'd1;
  localparam logic [2:0] OP_CLR  = 3'd2;
  localparam logic [2:0] OP_INC  = 3'd3;
  localparam logic [2:0] OP_DEC  = 3'd4;

  // Register-file function codes
  localparam logic [2:0] FUN_DEC  = 3'b000;
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] FUN_LOAD = 3'b010;
  localparam logic [2:0] FUN_CLR  = 3'b011;

  // S4 is the swap temporary
  localparam logic [2:0] CODE_S4 = 3'd7;

`ifdef REGFILE_SEQ_SWAP_EN
  typedef enum logic [1:0] {IDLE, STEP1, STEP2, STEP3} state_t;
`else
  typedef enum logic [1:0] {IDLE, STEP1} state_t;
`endif

  // Complete registered output bundle
  typedef struct packed {
    logic       ready;
    logic [2:0] asel;
    logic [2:0] bsel;
    logic [2:0] fun;
    logic [3:0] regsel;
    logic [3:0] scrsel;
    logic       done;
    logic       err;
  } outs_t;

  // One-hot write enable for a register code, returned as {RegSel, ScrSel}.
  // R1/S1 sit on bit 3 and R4/S4 on bit 0.
  function automatic logic [7:0] dst_enables(input logic [2:0] code);
    logic [3:0] onehot;
    onehot = 4'b1000 >> code[1:0];
    return code[2] ? {4'b0000, onehot} : {onehot, 4'b0000};
  endfunction

  // Output values while the sequencer is idle and ready for a command
  function automatic outs_t idle_outs(input logic done, input logic err);
    outs_t o;
    o        = '0;
    o.ready  = 1'b1;
    o.fun    = FUN_LOAD;
    o.done   = done;
    o.err    = err;
    return o;
  endfunction

  // Output values for a given step (1..3) of a command.
  // SWAP runs three steps: src -> S4, then dst -> src, then S4 -> dst.
  function automatic outs_t step_outs(input logic [1:0] step,
                                      input logic [2:0] op,
                                      input logic [2:0] src,
                                      input logic [2:0] dst);
    outs_t      o;
    logic [7:0] en;
    o      = '0;
    o.bsel = dst;
    o.fun  = FUN_LOAD;
    en     = 8'h00;
    case (op)
      OP_MOV: begin
        o.asel = src;
        en     = dst_enables(dst);
      end
      OP_CLR: begin
        o.fun = FUN_CLR;
        en    = dst_enables(dst);
      end
      OP_INC: begin
        o.fun = FUN_INC;
        en    = dst_enables(dst);
      end
      OP_DEC: begin
        o.fun = FUN_DEC;
        en    = dst_enables(dst);
      end
      OP_SWAP: begin
        case (step)
          2'd1: begin
            o.asel = src;
            en     = dst_enables(CODE_S4);
          end
          2'd2: begin
            o.asel = dst;
            en     = dst_enables(src);
          end
          default: begin
            o.asel = CODE_S4;
            en     = dst_enables(dst);
          end
        endcase
      end
      default: en = 8'h00;
    endcase
    {o.regsel, o.scrsel} = en;
    return o;
  endfunction

  state_t state_q, state_d;
  outs_t  outs_q, outs_d;
  logic   swap_ok;
  logic   cmd_illegal;

`ifdef REGFILE_SEQ_SWAP_EN
  logic [2:0] op_q, src_q, dst_q;
`endif

  // Legality of the command on the inputs; a swap also needs distinct
  // operands, and neither operand may be the S4 temporary
  always_comb begin
`ifdef REGFILE_SEQ_SWAP_EN
    swap_ok = (CmdSrc != CmdDst) && (CmdSrc != CODE_S4) && (CmdDst != CODE_S4);
`else
    swap_ok = 1'b0;
`endif
    cmd_illegal = (CmdOp > OP_DEC) || ((CmdOp == OP_SWAP) && !swap_ok);
  end

  // Next state and next registered outputs
  always_comb begin
    state_d = state_q;
    outs_d  = idle_outs(1'b0, 1'b0);
    case (state_q)
      IDLE: begin
        if (CmdValid) begin
          if (cmd_illegal) begin
            outs_d = idle_outs(1'b0, 1'b1);
          end else begin
            state_d = STEP1;
            outs_d  = step_outs(2'd1, CmdOp, CmdSrc, CmdDst);
          end
        end
      end
      STEP1: begin
        state_d = IDLE;
        outs_d  = idle_outs(1'b1, 1'b0);
`ifdef REGFILE_SEQ_SWAP_EN
        if (op_q == OP_SWAP) begin
          state_d = STEP2;
          outs_d  = step_outs(2'd2, op_q, src_q, dst_q);
        end
`endif
      end
`ifdef REGFILE_SEQ_SWAP_EN
      STEP2: begin
        state_d = STEP3;
        outs_d  = step_outs(2'd3, op_q, src_q, dst_q);
      end
      STEP3: begin
        state_d = IDLE;
        outs_d  = idle_outs(1'b1, 1'b0);
      end
`endif
      default: begin
        state_d = IDLE;
        outs_d  = idle_outs(1'b0, 1'b0);
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight command
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= IDLE;
      outs_q  <= idle_outs(1'b0, 1'b0);
    end else begin
      state_q <= state_d;
      outs_q  <= outs_d;
    end
  end

`ifdef REGFILE_SEQ_SWAP_EN
  // Latch the command fields on acceptance for the later swap steps
  always_ff @(posedge Clock) begin
    if (state_q == IDLE && CmdValid) begin
      op_q  <= CmdOp;
      src_q <= CmdSrc;
      dst_q <= CmdDst;
    end
  end
`endif

  assign CmdReady = outs_q.ready;
  assign OutASel  = outs_q.asel;
  assign OutBSel  = outs_q.bsel;
  assign FunSel   = outs_q.fun;
  assign RegSel   = outs_q.regsel;
  assign ScrSel   = outs_q.scrsel;
  assign Done     = outs_q.done;
  assign Err      = outs_q.err;

endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Command-driven control sequencer that drives the select/enable/function inputs of the 8-register file (R1–R4, S1–S4) to perform register-transfer micro-operations. Sits between the instruction control unit and the register file. Accepts one command at a time over a valid/ready handshake and expands it into 1–3 register-file cycles, using S4 as the temporary for swaps. The register file `I` input is wired externally to its own `OutA`, so every load copies the register selected by `OutASel`.

## Interface
- No parameters.
- `Clock` in 1: rising-edge clock, shared with the register file.
- `Reset` in 1: asynchronous, active-high.
- `CmdValid` in 1: command present.
- `CmdReady` out 1: sequencer idle, can accept; reset 1.
- `CmdOp` in 3: 0 MOV, 1 SWAP, 2 CLR, 3 INC, 4 DEC, 5–7 illegal.
- `CmdSrc` in 3: source register code; 0–3 = R1–R4, 4–7 = S1–S4.
- `CmdDst` in 3: destination register code, same encoding.
- `OutASel` out 3: register file read port A select; reset 000.
- `OutBSel` out 3: register file read port B select (observation); reset 000.
- `FunSel` out 3: register function; 000 decrement, 001 increment, 010 load, 011 clear; reset 010.
- `RegSel` out 4: R enables, bit3 = R1 … bit0 = R4, active-high; reset 0000.
- `ScrSel` out 4: S enables, bit3 = S1 … bit0 = S4, active-high; reset 0000.
- `Done` out 1: one-cycle completion pulse; reset 0.
- `Err` out 1: one-cycle rejected-command pulse; reset 0.

## Operation
- States: IDLE, STEP1, STEP2, STEP3.
- IDLE: `CmdReady`=1, all enables 0, `OutASel`=`OutBSel`=000, `FunSel`=010. On a rising edge with `CmdValid`=1, latch op/src/dst.
- Legal command → STEP1. Illegal command (op 5–7; SWAP with src==dst; SWAP with src or dst = 7 (S4); SWAP with `REGFILE_SEQ_SWAP_EN` undefined) → stay in IDLE, `Err`=1 for the next cycle, no enable ever asserted.
- Destination decode: code d sets exactly one enable bit; codes 0–3 hit `RegSel`, codes 4–7 hit `ScrSel`.
- MOV: STEP1 `OutASel`=src, `FunSel`=010, enable dst.
- CLR: STEP1 `FunSel`=011, enable dst; `CmdSrc` ignored.
- INC/DEC: STEP1 `FunSel`=001/000, enable dst; `CmdSrc` ignored.
- SWAP: STEP1 `OutASel`=src, load into S4. STEP2 `OutASel`=dst, load into src. STEP3 `OutASel`=7, load into dst.
- During all STEP states, `OutBSel`=latched dst.
- After the final step: return to IDLE and assert `Done`=1 for that first IDLE cycle.
- `Done` and `Err` are never asserted together.

## Timing
- All outputs are decoded from registered state and latched fields; there are no combinational paths from `CmdValid` or `Cmd*` to outputs.
- Write lands at the rising edge ending each STEP cycle.
- Latency from the acceptance edge to `Done`:
  - MOV/CLR/INC/DEC: 2 cycles, 1 write.
  - SWAP: 4 cycles, 3 writes.
  - Illegal: `Err` in the next cycle.
- `CmdReady` is low in STEP1–3.
- A new command may be accepted in the same cycle `Done` or `Err` is high, giving back-to-back throughput of one command per (steps + 1) cycles.
- `Cmd*` are don't-care while `CmdValid`=0 or `CmdReady`=0.
- Asserting `Reset` at any time immediately forces IDLE and all reset values. The in-flight command is abandoned without `Done`. An interrupted SWAP leaves partial state (S4 and/or src already overwritten); this is acceptable.

## Configuration
- `REGFILE_SEQ_SWAP_EN` defined: SWAP is supported, and STEP2/STEP3 are present.
- `REGFILE_SEQ_SWAP_EN` undefined: op 1 is illegal (`Err` pulse, no writes); the state machine reduces to IDLE/STEP1; S4 is never written implicitly.

## Test plan
- MOV: R2=0x0000_1234, `CmdOp`=0, src=1, dst=5 → one cycle with `OutASel`=001, `ScrSel`=0100, `FunSel`=010; S2=0x0000_1234; `Done` 2 cycles after acceptance.
- SWAP (macro on): R1=0xAAAA_0001, R3=0x5555_0003, src=0, dst=2 → S4 loaded, then R1, then R3 in three consecutive cycles; final R1=0x5555_0003, R3=0xAAAA_0001, S4=0xAAAA_0001; `Done` at cycle 4.
- INC then DEC back-to-back on R4=0xFFFF_FFFF → after INC, R4=0x0000_0000; second command accepted in the `Done` cycle; after DEC, R4=0xFFFF_FFFF; `CmdReady` pattern 1,0,1,0,1.
- Illegal: op=6, then SWAP src=dst=3, then SWAP dst=7 → each produces an `Err` pulse with no `Done`; `RegSel`/`ScrSel` stay 0000 throughout; register contents unchanged.
- Reset during SWAP STEP2 → in the same cycle, all enables 0, `CmdReady`=1, `FunSel`=010; no `Done`; next MOV completes normally.
- Macro off: SWAP command → `Err`=1, S4 unchanged; CLR on S1=0x1 → S1=0.
